lsq_param: RTL
==============

// Module: lsq_param
// PURPOSE
//  Parametrised in-order load/store queue between decoder/ROB and memory controller.
//  Captures operands from DEPTH-entry circular storage and CDB_N broadcast channels.
//  Issues loads speculatively from the head and committed stores non-speculatively.
//  Over the single-channel LSB it adds: count-based full (all DEPTH slots usable),
//  N wake-up channels, a valid/ready memory handshake, and flush that keeps committed stores.
// PARAMETERS
//  XLEN       32        data/address width
//  DEPTH      16        queue entries; power of two, >=2
//  TAG_W      4         ROB id width
//  CDB_N      2         number of result broadcast channels
//  MMIO_BASE  32'h30000 addresses >= this are I/O and non-speculative
// PORTS
//  clk            in   1             clock
//  rst            in   1             reset
//  rdy            in   1             global enable; state frozen when low
//  flush          in   1             mispredict squash
//  io_full        in   1             I/O buffer cannot accept
//  enq_valid      in   1             enqueue request (ignored when full)
//  enq_is_store   in   1             1=store, 0=load
//  enq_size       in   2             0=byte 1=half 2=word
//  enq_unsigned   in   1             zero-extend load
//  enq_rob_id     in   TAG_W         ROB id of instruction
//  enq_imm        in   XLEN          address offset
//  enq_rs1_busy   in   1             base register not ready
//  enq_rs1_tag    in   TAG_W         producer tag of base
//  enq_rs1_val    in   XLEN          base value when not busy
//  enq_rs2_busy   in   1             store data not ready (ignored for loads)
//  enq_rs2_tag    in   TAG_W         producer tag of store data
//  enq_rs2_val    in   XLEN          store data when not busy
//  cdb_valid      in   CDB_N         per-channel result valid
//  cdb_tag        in   CDB_N*TAG_W   per-channel tag, channel k at [k*TAG_W +: TAG_W]
//  cdb_data       in   CDB_N*XLEN    per-channel value
//  rob_head_id    in   TAG_W         ROB id at ROB head
//  commit_valid   in   1             ROB commits a store this cycle
//  commit_id      in   TAG_W         ROB id of committed store
//  mem_ready      in   1             memory controller accepts request
//  full           out  1             count==DEPTH
//  empty          out  1             count==0
//  count          out  $clog2(DEPTH+1) occupied entries
//  mem_valid      out  1             request valid (registered)
//  mem_we         out  1             1=store
//  mem_size       out  2             access size
//  mem_unsigned   out  1             load extension
//  mem_addr       out  XLEN          effective address
//  mem_wdata      out  XLEN          store data
//  mem_id         out  TAG_W         ROB id
// BEHAVIOUR
//  - Reset (sync, rdy high): head=tail=count=0; all entries invalid; mem_valid=0; other outs 0.
//  - Enqueue: enq_valid&&!full writes tail, tail+1 mod DEPTH, count+1.
//    Enqueue-and-dequeue in the same cycle leaves count unchanged.
//  - Address: rs1 ready -> addr=rs1_val+imm (XLEN wrap); else store imm and tag; on capture addr+=data.
//  - Capture: any cdb_valid[k] with matching tag clears busy. Applies to stored entries
//    and to the entry being enqueued that cycle. Lowest k wins on duplicate tags.
//  - Commit: commit_valid marks entry with rob_id==commit_id committed (sticky).
//  - Issue, only when !mem_valid || handshake this cycle. Candidate is the head entry (not yet issued):
//    - Load: addr ready. If addr>=MMIO_BASE, also require rob_id==rob_head_id && !io_full.
//    - Store: addr ready && data ready && committed.
//    - Issue registers mem_* next cycle.
//  - Handshake: mem_valid&&mem_ready dequeues head. mem_* stay stable while mem_valid&&!mem_ready.
//    Throughput is 1 request/cycle with mem_ready held high.
//  - Flush: tail := first uncommitted entry from head (committed stores retained); count adjusted.
//    A pending load request is dropped (mem_valid:=0). A pending store stays valid.
//    Enqueue and commit are ignored that cycle.
//  - Full: enq dropped, no state change. Empty: no issue. Pointer wrap DEPTH-1 -> 0.
//  - Misalignment is not checked; the address is passed through unchanged.
// TESTING
//  1. Load rs1 ready val=0x1000 imm=4 -> next cycle mem_valid, addr 0x1004, we=0; mem_ready=1 -> empty.
//  2. Store rs1 busy tag3, cdb ch1 tag3 data 0x20, imm 8, data ready, commit_id match
//     -> mem addr 0x28, we=1.
//  3. Fill DEPTH entries -> full=1, count=DEPTH; extra enq ignored. Drain -> pointers wrap, empty=1.
//  4. Load addr 0x30000, rob_head_id!=id -> no issue. Head matches, io_full=1 -> none;
//     io_full=0 -> issue.
//  5. Two committed stores then three loads, flush -> count=2, stores still issue in order.
//  6. Same-cycle enqueue with busy tag5 and cdb tag5 data 0x40 -> entry captures 0x40+imm.

Source files
------------

// File: rtl/lsq_param_if.sv
`default_nettype none
// ============================================================================
// Module      : lsq_param_if
// Description : Bundle of every LSQ-facing signal except clk/rst.
//               Covers control, enqueue, CDB broadcast, commit, status and
//               the memory request channel.
//               master = upstream/testbench side, slave = the queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsq_param_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int TAG_W = 4,
    parameter int CDB_N = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // control
    logic                   rdy;
    logic                   flush;
    logic                   io_full;
    // enqueue
    logic                   enq_valid;
    logic                   enq_is_store;
    logic [1:0]             enq_size;
    logic                   enq_unsigned;
    logic [TAG_W-1:0]       enq_rob_id;
    logic [XLEN-1:0]        enq_imm;
    logic                   enq_rs1_busy;
    logic [TAG_W-1:0]       enq_rs1_tag;
    logic [XLEN-1:0]        enq_rs1_val;
    logic                   enq_rs2_busy;
    logic [TAG_W-1:0]       enq_rs2_tag;
    logic [XLEN-1:0]        enq_rs2_val;
    // result broadcast
    logic [CDB_N-1:0]       cdb_valid;
    logic [CDB_N*TAG_W-1:0] cdb_tag;
    logic [CDB_N*XLEN-1:0]  cdb_data;
    // ROB
    logic [TAG_W-1:0]       rob_head_id;
    logic                   commit_valid;
    logic [TAG_W-1:0]       commit_id;
    // status
    logic                   full;
    logic                   empty;
    logic [CNT_W-1:0]       count;
    // memory request channel
    logic                   mem_ready;
    logic                   mem_valid;
    logic                   mem_we;
    logic [1:0]             mem_size;
    logic                   mem_unsigned;
    logic [XLEN-1:0]        mem_addr;
    logic [XLEN-1:0]        mem_wdata;
    logic [TAG_W-1:0]       mem_id;

    modport master (
        output rdy, flush, io_full,
        output enq_valid, enq_is_store, enq_size, enq_unsigned, enq_rob_id, enq_imm,
        output enq_rs1_busy, enq_rs1_tag, enq_rs1_val,
        output enq_rs2_busy, enq_rs2_tag, enq_rs2_val,
        output cdb_valid, cdb_tag, cdb_data,
        output rob_head_id, commit_valid, commit_id, mem_ready,
        input  full, empty, count,
        input  mem_valid, mem_we, mem_size, mem_unsigned, mem_addr, mem_wdata, mem_id
    );

    modport slave (
        input  rdy, flush, io_full,
        input  enq_valid, enq_is_store, enq_size, enq_unsigned, enq_rob_id, enq_imm,
        input  enq_rs1_busy, enq_rs1_tag, enq_rs1_val,
        input  enq_rs2_busy, enq_rs2_tag, enq_rs2_val,
        input  cdb_valid, cdb_tag, cdb_data,
        input  rob_head_id, commit_valid, commit_id, mem_ready,
        output full, empty, count,
        output mem_valid, mem_we, mem_size, mem_unsigned, mem_addr, mem_wdata, mem_id
    );
endinterface
`default_nettype wire

// File: rtl/lsq_param.sv
`default_nettype none
// ============================================================================
// Module      : lsq_param
// Description : Parametrised in-order load/store queue. Entries capture their
//               operands from CDB_N broadcast channels. Loads issue
//               speculatively from the head; I/O loads wait for the ROB head.
//               Stores issue only once committed. Flush keeps the committed
//               stores sitting at the head.
// Revision    : 1.0 - initial release
// ============================================================================
module lsq_param #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 16,
    parameter int              TAG_W     = 4,
    parameter int              CDB_N     = 2,
    parameter logic [XLEN-1:0] MMIO_BASE = 'h30000
) (
    input wire         clk,
    input wire         rst,
    lsq_param_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // per-entry storage; occupancy tracked by r_valid
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_store;
    logic [DEPTH-1:0] r_uns;
    logic [DEPTH-1:0] r_abusy;
    logic [DEPTH-1:0] r_dbusy;
    logic [DEPTH-1:0] r_commit;
    logic [DEPTH-1:0] r_issued;
    logic [1:0]       r_size [DEPTH];
    logic [TAG_W-1:0] r_rob  [DEPTH];
    logic [TAG_W-1:0] r_atag [DEPTH];
    logic [TAG_W-1:0] r_dtag [DEPTH];
    logic [XLEN-1:0]  r_addr [DEPTH];
    logic [XLEN-1:0]  r_data [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             r_mem_valid;
    logic             r_mem_we;
    logic [1:0]       r_mem_size;
    logic             r_mem_uns;
    logic [XLEN-1:0]  r_mem_addr;
    logic [XLEN-1:0]  r_mem_wdata;
    logic [TAG_W-1:0] r_mem_id;

    logic             w_full;
    logic             w_fire;
    logic             w_deq;
    logic             w_enq;
    logic [PTR_W-1:0] w_cand;
    logic             w_cand_ok;
    logic             w_issue;
    logic [CNT_W-1:0] w_keep;
    logic             w_scan_stop;
    logic [PTR_W-1:0] w_scan_idx;
    logic             w_e1_hit;
    logic             w_e2_hit;
    logic [XLEN-1:0]  w_e1_val;
    logic [XLEN-1:0]  w_e2_val;
    logic             w_enq_abusy;
    logic             w_enq_dbusy;
    logic [XLEN-1:0]  w_enq_addr;
    logic [XLEN-1:0]  w_enq_data;

    // any channel broadcasting this tag
    function automatic logic cdb_hit(input logic [TAG_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < CDB_N; k++) begin
            if (bus.cdb_valid[k] && bus.cdb_tag[k*TAG_W +: TAG_W] == tag) hit = 1'b1;
        end
        return hit;
    endfunction

    // value for this tag; scanning downwards lets the lowest channel win
    function automatic logic [XLEN-1:0] cdb_val(input logic [TAG_W-1:0] tag);
        logic [XLEN-1:0] val;
        val = '0;
        for (int k = CDB_N - 1; k >= 0; k--) begin
            if (bus.cdb_valid[k] && bus.cdb_tag[k*TAG_W +: TAG_W] == tag)
                val = bus.cdb_data[k*XLEN +: XLEN];
        end
        return val;
    endfunction

    assign w_full = (r_count == CNT_W'(DEPTH));
    assign w_fire = bus.rdy && r_mem_valid && bus.mem_ready;
    // a load dropped by flush is squashed with the rest, not dequeued
    assign w_deq  = w_fire && !(bus.flush && !r_mem_we);
    assign w_enq  = bus.rdy && !bus.flush && bus.enq_valid && !w_full;
    // while the head is being accepted, the next entry may issue behind it
    assign w_cand = w_fire ? r_head + PTR_W'(1) : r_head;

    // issue eligibility of the candidate entry
    always_comb begin
        w_cand_ok = 1'b0;
        if (r_valid[w_cand] && !r_issued[w_cand] && !r_abusy[w_cand]) begin
            if (r_store[w_cand])
                w_cand_ok = !r_dbusy[w_cand] && r_commit[w_cand];
            else
                w_cand_ok = (r_addr[w_cand] < MMIO_BASE) ||
                            (r_rob[w_cand] == bus.rob_head_id && !bus.io_full);
        end
    end

    assign w_issue = bus.rdy && !bus.flush && (!r_mem_valid || w_fire) && w_cand_ok;

    // number of consecutive committed entries starting at the head
    always_comb begin
        w_keep      = '0;
        w_scan_stop = 1'b0;
        w_scan_idx  = r_head;
        for (int j = 0; j < DEPTH; j++) begin
            w_scan_idx = r_head + PTR_W'(j);
            if (!w_scan_stop && r_valid[w_scan_idx] && r_commit[w_scan_idx])
                w_keep = w_keep + CNT_W'(1);
            else
                w_scan_stop = 1'b1;
        end
    end

    // operands of the entry being enqueued, including same-cycle capture
    always_comb begin
        w_e1_hit    = cdb_hit(bus.enq_rs1_tag);
        w_e2_hit    = cdb_hit(bus.enq_rs2_tag);
        w_e1_val    = cdb_val(bus.enq_rs1_tag);
        w_e2_val    = cdb_val(bus.enq_rs2_tag);
        w_enq_abusy = bus.enq_rs1_busy && !w_e1_hit;
        w_enq_dbusy = bus.enq_is_store && bus.enq_rs2_busy && !w_e2_hit;
        if (!bus.enq_rs1_busy)
            w_enq_addr = bus.enq_rs1_val + bus.enq_imm;
        else if (w_e1_hit)
            w_enq_addr = w_e1_val + bus.enq_imm;
        else
            w_enq_addr = bus.enq_imm;
        w_enq_data = bus.enq_rs2_busy ? w_e2_val : bus.enq_rs2_val;
    end

    // queue state, operand capture, commit marking and request register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '0;
            r_store     <= '0;
            r_uns       <= '0;
            r_abusy     <= '0;
            r_dbusy     <= '0;
            r_commit    <= '0;
            r_issued    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_size[i] <= '0;
                r_rob[i]  <= '0;
                r_atag[i] <= '0;
                r_dtag[i] <= '0;
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_size  <= '0;
            r_mem_uns   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_id    <= '0;
        end else if (bus.rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i] && r_abusy[i] && cdb_hit(r_atag[i])) begin
                    r_abusy[i] <= 1'b0;
                    r_addr[i]  <= r_addr[i] + cdb_val(r_atag[i]);
                end
                if (r_valid[i] && r_dbusy[i] && cdb_hit(r_dtag[i])) begin
                    r_dbusy[i] <= 1'b0;
                    r_data[i]  <= cdb_val(r_dtag[i]);
                end
                if (!bus.flush && bus.commit_valid && r_valid[i] && r_store[i] &&
                    r_rob[i] == bus.commit_id)
                    r_commit[i] <= 1'b1;
                if (bus.flush && CNT_W'(PTR_W'(i) - r_head) >= w_keep)
                    r_valid[i] <= 1'b0;
            end

            if (w_issue) begin
                r_issued[w_cand] <= 1'b1;
                r_mem_valid      <= 1'b1;
                r_mem_we         <= r_store[w_cand];
                r_mem_size       <= r_size[w_cand];
                r_mem_uns        <= r_uns[w_cand];
                r_mem_addr       <= r_addr[w_cand];
                r_mem_wdata      <= r_data[w_cand];
                r_mem_id         <= r_rob[w_cand];
            end else if (w_fire || (bus.flush && !r_mem_we)) begin
                r_mem_valid <= 1'b0;
            end

            if (w_enq) begin
                r_valid[r_tail]  <= 1'b1;
                r_issued[r_tail] <= 1'b0;
                r_commit[r_tail] <= 1'b0;
                r_store[r_tail]  <= bus.enq_is_store;
                r_uns[r_tail]    <= bus.enq_unsigned;
                r_size[r_tail]   <= bus.enq_size;
                r_rob[r_tail]    <= bus.enq_rob_id;
                r_abusy[r_tail]  <= w_enq_abusy;
                r_atag[r_tail]   <= bus.enq_rs1_tag;
                r_addr[r_tail]   <= w_enq_addr;
                r_dbusy[r_tail]  <= w_enq_dbusy;
                r_dtag[r_tail]   <= bus.enq_rs2_tag;
                r_data[r_tail]   <= w_enq_data;
            end

            if (w_deq) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end

            if (bus.flush) begin
                r_tail  <= r_head + PTR_W'(w_keep);
                r_count <= w_keep - CNT_W'(w_deq);
            end else begin
                if (w_enq) r_tail <= r_tail + PTR_W'(1);
                r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
            end
        end
    end

    assign bus.full         = w_full;
    assign bus.empty        = (r_count == '0);
    assign bus.count        = r_count;
    assign bus.mem_valid    = r_mem_valid;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_size     = r_mem_size;
    assign bus.mem_unsigned = r_mem_uns;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.mem_id       = r_mem_id;
endmodule
`default_nettype wire
